// File: rtl/uart_mem_loader_pkg.sv
// Shared types and constants for the UART serial boot loader.
// Covers FSM encoding, frame sync bytes, CPU register map and STATUS layout.
package uart_mem_loader_pkg;

  localparam int unsigned WORD_W    = 32;
  localparam int unsigned BYTE_W    = 8;
  localparam int unsigned REG_IDX_W = 3;

  typedef enum logic [3:0] {
    S_IDLE,
    S_SYNC0,
    S_SYNC1,
    S_ADDR,
    S_LEN,
    S_DATA,
    S_WRITE,
    S_CKSUM,
    S_DONE,
    S_ERR
  } state_t;

  typedef enum logic [2:0] {
    E_NONE,
    E_CKSUM,
    E_OVERRUN,
    E_TIMEOUT,
    E_LEN
  } err_t;

  typedef struct packed {
    logic [WORD_W-1:0] addr;
    logic [WORD_W-1:0] data;
  } mem_wr_t;

  localparam logic [BYTE_W-1:0] SYNC0_BYTE = 8'h55;
  localparam logic [BYTE_W-1:0] SYNC1_BYTE = 8'hAA;

  localparam logic [REG_IDX_W-1:0] REG_CTRL   = 3'd0;
  localparam logic [REG_IDX_W-1:0] REG_STATUS = 3'd1;
  localparam logic [REG_IDX_W-1:0] REG_BASE   = 3'd2;
  localparam logic [REG_IDX_W-1:0] REG_COUNT  = 3'd3;
  localparam logic [REG_IDX_W-1:0] REG_CKSUM  = 3'd4;

  localparam int unsigned CTRL_ARM   = 0;
  localparam int unsigned CTRL_CLEAR = 1;

  localparam int unsigned ST_BUSY        = 0;
  localparam int unsigned ST_DONE        = 1;
  localparam int unsigned ST_ERR_CKSUM   = 2;
  localparam int unsigned ST_ERR_OVERRUN = 3;
  localparam int unsigned ST_ERR_TIMEOUT = 4;
  localparam int unsigned ST_ERR_LEN     = 5;

  // States in which an idle UART line counts toward the timeout.
  function automatic logic is_timed(input state_t s);
    return (s == S_ADDR) || (s == S_LEN) || (s == S_DATA) || (s == S_CKSUM);
  endfunction

  // States that feed bytes into the little-endian word assembler.
  function automatic logic is_field(input state_t s);
    return (s == S_ADDR) || (s == S_LEN) || (s == S_DATA);
  endfunction

  // States during which the loader owns the UART byte stream.
  function automatic logic in_frame(input state_t s);
    return (s != S_IDLE) && (s != S_DONE) && (s != S_ERR);
  endfunction

endpackage

// File: rtl/loader_byte_assembler.sv
// Collects four little-endian bytes into a 32-bit word.
// The completed word and the last-byte flag are presented in the cycle of the 4th byte.
module loader_byte_assembler
  import uart_mem_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_clear,
  input  logic              i_valid,
  input  logic [BYTE_W-1:0] i_byte,
  output logic [WORD_W-1:0] o_word_c,
  output logic              o_last_c
);

  logic [WORD_W-BYTE_W-1:0] r_shift;
  logic [1:0]               r_cnt;

  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_shift <= '0;
      r_cnt   <= '0;
    end else if (i_valid) begin
      r_shift <= {i_byte, r_shift[WORD_W-BYTE_W-1:BYTE_W]};
      r_cnt   <= r_cnt + 2'd1;
    end
  end

  assign o_word_c = {i_byte, r_shift};
  assign o_last_c = i_valid && (r_cnt == 2'd3);

endmodule

// File: rtl/uart_mem_loader.sv
// Serial boot loader: parses one framed image from the UART stream and writes
// its payload through the memory controller override port, then checks the sum.
module uart_mem_loader
  import uart_mem_loader_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 62500000,
  parameter logic [31:0] MAX_WORDS      = 32'h0010_0000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [REG_IDX_W-1:0] a,
  input  logic [WORD_W-1:0]    d,
  input  logic                 we,
  output logic [WORD_W-1:0]    spo,
  output logic                 ready,
  output logic                 uart_override,
  input  logic [BYTE_W-1:0]    uart_data,
  input  logic                 uart_ready,
  output logic                 mem_override,
  output logic [WORD_W-1:0]    mem_a,
  output logic [WORD_W-1:0]    mem_d,
  output logic                 mem_we,
  input  logic                 mem_ready
);

  localparam logic [WORD_W-1:0] TMO_LAST = WORD_W'(TIMEOUT_CYCLES - 1);
  localparam bit                TMO_EN   = (TIMEOUT_CYCLES != 0);

  state_t            r_state;
  state_t            w_next;
  err_t              w_err;
  logic              w_arm;
  logic              w_clr;
  logic              w_asm_valid;
  logic              w_asm_clear;
  logic              w_asm_last;
  logic [WORD_W-1:0] w_asm_word;
  logic              w_tmo_hit;
  logic              w_count_inc;
  logic              w_unused_d;

  logic [WORD_W-1:0] r_base;
  logic [WORD_W-1:0] r_len;
  logic [WORD_W-1:0] r_count;
  logic [WORD_W-1:0] r_tmo;
  logic [BYTE_W-1:0] r_cksum;
  mem_wr_t           r_wr;
  logic              r_mem_we;
  logic              r_uart_ovr;
  logic              r_mem_ovr;
  logic              r_busy;
  logic              r_done;
  logic              r_err_cksum;
  logic              r_err_overrun;
  logic              r_err_timeout;
  logic              r_err_len;

  assign w_arm       = we && (a == REG_CTRL) && d[CTRL_ARM] && (r_state == S_IDLE);
  assign w_clr       = we && (a == REG_CTRL) && d[CTRL_CLEAR];
  assign w_unused_d  = ^d[WORD_W-1:2];
  assign w_asm_valid = uart_ready && is_field(r_state);
  assign w_asm_clear = !is_field(r_state);
  assign w_tmo_hit   = TMO_EN && is_timed(r_state) && !uart_ready && (r_tmo == TMO_LAST);

  loader_byte_assembler u_asm (
    .clk      (clk),
    .rst      (rst),
    .i_clear  (w_asm_clear),
    .i_valid  (w_asm_valid),
    .i_byte   (uart_data),
    .o_word_c (w_asm_word),
    .o_last_c (w_asm_last)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Frame parser; an idle-line timeout overrides whatever the byte path decided.
  always_comb begin
    w_next      = r_state;
    w_err       = E_NONE;
    w_count_inc = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_arm) w_next = S_SYNC0;
      end
      S_SYNC0: begin
        if (uart_ready && (uart_data == SYNC0_BYTE)) w_next = S_SYNC1;
      end
      S_SYNC1: begin
        if (uart_ready) begin
          if (uart_data == SYNC1_BYTE)      w_next = S_ADDR;
          else if (uart_data != SYNC0_BYTE) w_next = S_SYNC0;
        end
      end
      S_ADDR: begin
        if (w_asm_last) w_next = S_LEN;
      end
      S_LEN: begin
        if (w_asm_last) begin
          if (w_asm_word > MAX_WORDS) begin
            w_next = S_ERR;
            w_err  = E_LEN;
          end else if (w_asm_word == '0) begin
            w_next = S_CKSUM;
          end else begin
            w_next = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (w_asm_last) w_next = S_WRITE;
      end
      S_WRITE: begin
        if (uart_ready) begin
          w_next = S_ERR;
          w_err  = E_OVERRUN;
        end else if (mem_ready) begin
          w_count_inc = 1'b1;
          w_next      = ((r_count + 32'd1) == r_len) ? S_CKSUM : S_DATA;
        end
      end
      S_CKSUM: begin
        if (uart_ready) begin
          if (uart_data == r_cksum) begin
            w_next = S_DONE;
          end else begin
            w_next = S_ERR;
            w_err  = E_CKSUM;
          end
        end
      end
      S_DONE, S_ERR: w_next = S_IDLE;
      default:       w_next = S_IDLE;
    endcase
    if (w_tmo_hit) begin
      w_next = S_ERR;
      w_err  = E_TIMEOUT;
    end
  end

  // Frame datapath: header capture, payload accounting and memory write request.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_base     <= '0;
      r_len      <= '0;
      r_count    <= '0;
      r_cksum    <= '0;
      r_tmo      <= '0;
      r_wr       <= '0;
      r_mem_we   <= 1'b0;
      r_uart_ovr <= 1'b0;
      r_mem_ovr  <= 1'b0;
    end else begin
      if (w_arm) begin
        r_count <= '0;
        r_cksum <= '0;
      end
      if ((r_state == S_ADDR) && w_asm_last) r_base <= {w_asm_word[WORD_W-1:2], 2'b00};
      if ((r_state == S_LEN) && w_asm_last)  r_len  <= w_asm_word;
      if ((r_state == S_DATA) && uart_ready) r_cksum <= r_cksum + uart_data;
      if (w_count_inc) r_count <= r_count + 32'd1;
      if ((r_state == S_DATA) && (w_next == S_WRITE)) begin
        r_wr.addr <= r_base + {r_count[WORD_W-3:0], 2'b00};
        r_wr.data <= w_asm_word;
      end
      if (uart_ready || !is_timed(r_state)) r_tmo <= '0;
      else                                  r_tmo <= r_tmo + 32'd1;
      r_mem_we   <= (w_next == S_WRITE);
      r_uart_ovr <= in_frame(w_next);
      if (w_next == S_DATA)                                 r_mem_ovr <= 1'b1;
      else if ((w_next != S_WRITE) && (w_next != S_CKSUM))  r_mem_ovr <= 1'b0;
    end
  end

  // Sticky status; a new error or completion outranks a simultaneous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_err_cksum   <= 1'b0;
      r_err_overrun <= 1'b0;
      r_err_timeout <= 1'b0;
      r_err_len     <= 1'b0;
    end else begin
      if (w_arm)                                        r_busy <= 1'b1;
      else if ((w_next == S_DONE) || (w_next == S_ERR)) r_busy <= 1'b0;
      if (w_clr) begin
        r_done        <= 1'b0;
        r_err_cksum   <= 1'b0;
        r_err_overrun <= 1'b0;
        r_err_timeout <= 1'b0;
        r_err_len     <= 1'b0;
      end
      if (w_next == S_DONE) r_done <= 1'b1;
      case (w_err)
        E_CKSUM:   r_err_cksum   <= 1'b1;
        E_OVERRUN: r_err_overrun <= 1'b1;
        E_TIMEOUT: r_err_timeout <= 1'b1;
        E_LEN:     r_err_len     <= 1'b1;
        default:   ;
      endcase
    end
  end

  always_comb begin
    spo = '0;
    case (a)
      REG_STATUS: begin
        spo[ST_BUSY]        = r_busy;
        spo[ST_DONE]        = r_done;
        spo[ST_ERR_CKSUM]   = r_err_cksum;
        spo[ST_ERR_OVERRUN] = r_err_overrun;
        spo[ST_ERR_TIMEOUT] = r_err_timeout;
        spo[ST_ERR_LEN]     = r_err_len;
      end
      REG_BASE:  spo = r_base;
      REG_COUNT: spo = r_count;
      REG_CKSUM: spo = {{(WORD_W-BYTE_W){1'b0}}, r_cksum};
      default:   spo = '0;
    endcase
  end

  assign ready         = 1'b1;
  assign uart_override = r_uart_ovr;
  assign mem_override  = r_mem_ovr;
  assign mem_a         = r_wr.addr;
  assign mem_d         = r_wr.data;
  assign mem_we        = r_mem_we;

endmodule
